// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the loadable countdown timer.
package countdown_timer_pkg;

  localparam int unsigned COUNTDOWN_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Load handshake, run control and status bundle for countdown_timer.
interface countdown_timer_if
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH = COUNTDOWN_WIDTH
);

  logic             load_valid_i;
  logic             load_ready_o;
  logic [WIDTH-1:0] data_i;
  logic             enable_i;
  logic             abort_i;
  logic [WIDTH-1:0] count_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output load_valid_i, data_i, enable_i, abort_i,
    input  load_ready_o, count_o, busy_o, done_o
  );

  modport slave (
    input  load_valid_i, data_i, enable_i, abort_i,
    output load_ready_o, count_o, busy_o, done_o
  );

endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle terminal-count pulse.
// COUNTDOWN_TIMER_RELOAD_EN adds auto_reload_i for periodic operation.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH = COUNTDOWN_WIDTH
) (
  input  logic clk_i,
  input  logic rst_ni,
`ifdef COUNTDOWN_TIMER_RELOAD_EN
  input  logic auto_reload_i,
`endif
  countdown_timer_if.slave tmr
);

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic             done_q;
`ifdef COUNTDOWN_TIMER_RELOAD_EN
  logic [WIDTH-1:0] reload_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      done_q   <= 1'b0;
`ifdef COUNTDOWN_TIMER_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tmr.load_valid_i) begin
`ifdef COUNTDOWN_TIMER_RELOAD_EN
            reload_q <= tmr.data_i;
`endif
            if (tmr.data_i != '0) begin
              count_q <= tmr.data_i;
              state_q <= ST_RUN;
            end else begin
              count_q <= '0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (tmr.abort_i) begin
            count_q <= '0;
            state_q <= ST_IDLE;
          end else if (tmr.enable_i) begin
            if (count_q > WIDTH'(1)) begin
              count_q <= count_q - WIDTH'(1);
            end else begin
              // Terminal edge; count is never 0 here since a zero load bypasses RUN.
              done_q <= 1'b1;
`ifdef COUNTDOWN_TIMER_RELOAD_EN
              if (auto_reload_i) begin
                count_q <= reload_q;
              end else begin
                count_q <= '0;
                state_q <= ST_DONE;
              end
`else
              count_q <= '0;
              state_q <= ST_DONE;
`endif
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  assign tmr.count_o      = count_q;
  assign tmr.done_o       = done_q;
  assign tmr.busy_o       = (state_q == ST_RUN);
  assign tmr.load_ready_o = (state_q == ST_IDLE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
module tb_countdown_timer;

  localparam int unsigned W = 4;

  logic clk_i;
  logic rst_ni;
`ifdef COUNTDOWN_TIMER_RELOAD_EN
  logic auto_reload;
`endif
  int total = 0;
  int bad   = 0;

  countdown_timer_if #(.WIDTH(W)) tif ();

  countdown_timer #(.WIDTH(W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
`ifdef COUNTDOWN_TIMER_RELOAD_EN
    .auto_reload_i (auto_reload),
`endif
    .tmr           (tif.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle before sampling/driving.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (tif.count_o !== 4'd0 || tif.busy_o !== 1'b0 || tif.load_ready_o !== 1'b1 || tif.done_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got cnt=%0d busy=%b rdy=%b done=%b exp cnt=0 busy=0 rdy=1 done=0",
               tif.count_o, tif.busy_o, tif.load_ready_o, tif.done_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_count3();
    logic [W-1:0] exp_cnt [3] = '{4'd2, 4'd1, 4'd0};
    tif.load_valid_i = 1'b1; tif.data_i = 4'd3; tif.enable_i = 1'b1;
    step();
    tif.load_valid_i = 1'b0;
    total++;
    if (tif.count_o !== 4'd3 || tif.busy_o !== 1'b1 || tif.load_ready_o !== 1'b0 || tif.done_o !== 1'b0) begin
      bad++;
      $display("FAIL count3_load got cnt=%0d busy=%b rdy=%b done=%b exp cnt=3 busy=1 rdy=0 done=0",
               tif.count_o, tif.busy_o, tif.load_ready_o, tif.done_o);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (tif.count_o !== exp_cnt[i] || tif.done_o !== (i == 2)) begin
        bad++;
        $display("FAIL count3_edge%0d got cnt=%0d done=%b exp cnt=%0d done=%b",
                 i + 1, tif.count_o, tif.done_o, exp_cnt[i], (i == 2));
      end
    end
    step();
    total++;
    if (tif.done_o !== 1'b0 || tif.load_ready_o !== 1'b1 || tif.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL count3_after got done=%b rdy=%b busy=%b exp done=0 rdy=1 busy=0",
               tif.done_o, tif.load_ready_o, tif.busy_o);
    end
  endtask

  task automatic test_enable_gaps();
    logic          en_seq  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0]  exp_cnt [6] = '{4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
    tif.load_valid_i = 1'b1; tif.data_i = 4'd4; tif.enable_i = 1'b0;
    step();
    tif.load_valid_i = 1'b0;
    total++;
    if (tif.count_o !== 4'd4 || tif.busy_o !== 1'b1) begin
      bad++;
      $display("FAIL gaps_load got cnt=%0d busy=%b exp cnt=4 busy=1", tif.count_o, tif.busy_o);
    end
    for (int i = 0; i < 6; i++) begin
      tif.enable_i = en_seq[i];
      step();
      total++;
      if (tif.count_o !== exp_cnt[i] || tif.done_o !== (i == 5)) begin
        bad++;
        $display("FAIL gaps_edge%0d got cnt=%0d done=%b exp cnt=%0d done=%b",
                 i + 1, tif.count_o, tif.done_o, exp_cnt[i], (i == 5));
      end
    end
    step();
    total++;
    if (tif.done_o !== 1'b0 || tif.load_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL gaps_after got done=%b rdy=%b exp done=0 rdy=1", tif.done_o, tif.load_ready_o);
    end
  endtask

  task automatic test_load_zero();
    tif.load_valid_i = 1'b1; tif.data_i = 4'd0; tif.enable_i = 1'b1;
    step();
    tif.load_valid_i = 1'b0;
    total++;
    if (tif.done_o !== 1'b1 || tif.busy_o !== 1'b0 || tif.count_o !== 4'd0 || tif.load_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL zero_pulse got done=%b busy=%b cnt=%0d rdy=%b exp done=1 busy=0 cnt=0 rdy=0",
               tif.done_o, tif.busy_o, tif.count_o, tif.load_ready_o);
    end
    step();
    total++;
    if (tif.done_o !== 1'b0 || tif.busy_o !== 1'b0 || tif.load_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL zero_after got done=%b busy=%b rdy=%b exp done=0 busy=0 rdy=1",
               tif.done_o, tif.busy_o, tif.load_ready_o);
    end
  endtask

  task automatic test_abort();
    tif.load_valid_i = 1'b1; tif.data_i = 4'd2; tif.enable_i = 1'b1;
    step();
    tif.load_valid_i = 1'b0;
    step();
    total++;
    if (tif.count_o !== 4'd1) begin
      bad++;
      $display("FAIL abort_pre got cnt=%0d exp cnt=1", tif.count_o);
    end
    tif.abort_i = 1'b1;
    step();
    tif.abort_i = 1'b0;
    total++;
    if (tif.count_o !== 4'd0 || tif.done_o !== 1'b0 || tif.busy_o !== 1'b0 || tif.load_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL abort_wins got cnt=%0d done=%b busy=%b rdy=%b exp cnt=0 done=0 busy=0 rdy=1",
               tif.count_o, tif.done_o, tif.busy_o, tif.load_ready_o);
    end
    step();
    total++;
    if (tif.done_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_nodone got done=%b exp done=0", tif.done_o);
    end
  endtask

  task automatic test_load_in_run();
    tif.load_valid_i = 1'b1; tif.data_i = 4'd5; tif.enable_i = 1'b0;
    step();
    tif.data_i = 4'd9;
    step();
    tif.load_valid_i = 1'b0;
    total++;
    if (tif.count_o !== 4'd5 || tif.busy_o !== 1'b1 || tif.load_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL run_load_ignored got cnt=%0d busy=%b rdy=%b exp cnt=5 busy=1 rdy=0",
               tif.count_o, tif.busy_o, tif.load_ready_o);
    end
    tif.abort_i = 1'b1;
    step();
    tif.abort_i = 1'b0;
    total++;
    if (tif.load_ready_o !== 1'b1 || tif.count_o !== 4'd0) begin
      bad++;
      $display("FAIL run_load_exit got rdy=%b cnt=%0d exp rdy=1 cnt=0", tif.load_ready_o, tif.count_o);
    end
  endtask

  task automatic test_reset_mid();
    tif.load_valid_i = 1'b1; tif.data_i = 4'd5; tif.enable_i = 1'b0;
    step();
    tif.load_valid_i = 1'b0; tif.enable_i = 1'b1;
    #1;
    rst_ni = 1'b0;
    #1;
    total++;
    if (tif.count_o !== 4'd0 || tif.busy_o !== 1'b0 || tif.load_ready_o !== 1'b1 || tif.done_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_run got cnt=%0d busy=%b rdy=%b done=%b exp cnt=0 busy=0 rdy=1 done=0",
               tif.count_o, tif.busy_o, tif.load_ready_o, tif.done_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (tif.done_o !== 1'b0 || tif.busy_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_nodone%0d got done=%b busy=%b exp done=0 busy=0", i, tif.done_o, tif.busy_o);
      end
    end
    tif.load_valid_i = 1'b1; tif.data_i = 4'd0;
    step();
    tif.load_valid_i = 1'b0;
    #1;
    rst_ni = 1'b0;
    #1;
    total++;
    if (tif.done_o !== 1'b0 || tif.load_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_done got done=%b rdy=%b exp done=0 rdy=1", tif.done_o, tif.load_ready_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

`ifdef COUNTDOWN_TIMER_RELOAD_EN
  task automatic test_reload();
    logic [W-1:0] exp_cnt  [6] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd0};
    logic         exp_done [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    auto_reload = 1'b1;
    tif.load_valid_i = 1'b1; tif.data_i = 4'd2; tif.enable_i = 1'b1;
    step();
    tif.load_valid_i = 1'b0;
    total++;
    if (tif.count_o !== 4'd2) begin
      bad++;
      $display("FAIL reload_load got cnt=%0d exp cnt=2", tif.count_o);
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 4) auto_reload = 1'b0;
      step();
      total++;
      if (tif.count_o !== exp_cnt[i] || tif.done_o !== exp_done[i] || tif.busy_o !== (i < 5)) begin
        bad++;
        $display("FAIL reload_edge%0d got cnt=%0d done=%b busy=%b exp cnt=%0d done=%b busy=%b",
                 i + 1, tif.count_o, tif.done_o, tif.busy_o, exp_cnt[i], exp_done[i], (i < 5));
      end
    end
    step();
    total++;
    if (tif.load_ready_o !== 1'b1 || tif.done_o !== 1'b0) begin
      bad++;
      $display("FAIL reload_idle got rdy=%b done=%b exp rdy=1 done=0", tif.load_ready_o, tif.done_o);
    end
  endtask
`endif

  initial begin
    rst_ni = 1'b0;
    tif.load_valid_i = 1'b0;
    tif.data_i       = '0;
    tif.enable_i     = 1'b0;
    tif.abort_i      = 1'b0;
`ifdef COUNTDOWN_TIMER_RELOAD_EN
    auto_reload = 1'b0;
`endif
    test_reset();
    test_count3();
    test_enable_gaps();
    test_load_zero();
    test_abort();
    test_load_in_run();
    test_reset_mid();
`ifdef COUNTDOWN_TIMER_RELOAD_EN
    test_reload();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
